// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential unsigned divider.
// Holds the FSM state encoding and the iteration counter sizing.
package div_pkg;

  localparam int DIV_WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } div_state_t;

  // Counter must hold 0..WIDTH without wrapping.
  function automatic int div_cnt_w(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/divider_control.sv
// Divider sequencing: FSM, iteration counter and handshake flags.
// Datapath strobes are decoded from state; busy/rdy are registered.
module divider_control
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic divisor_zero,
  input  logic trial_sign,
  output logic load,
  output logic shift_en,
  output logic accept,
  output logic last,
  output logic busy,
  output logic rdy
);

  localparam int CW = div_cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  div_state_t     state;
  logic [CW-1:0]  count;

  // Strobes to the datapath for the current cycle.
  always_comb begin
    load     = (state == S_IDLE) && run;
    shift_en = (state == S_ITER);
    accept   = shift_en && !trial_sign;
    last     = shift_en && (count == LAST_CNT);
  end

  // State, counter and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      count <= '0;
      busy  <= 1'b0;
      rdy   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (run) begin
            count <= '0;
            if (divisor_zero) begin
              state <= S_DONE;
              rdy   <= 1'b1;
            end else begin
              state <= S_ITER;
              busy  <= 1'b1;
            end
          end
        end
        S_ITER: begin
          count <= count + 1'b1;
          if (count == LAST_CNT) begin
            state <= S_DONE;
            busy  <= 1'b0;
            rdy   <= 1'b1;
          end
        end
        S_DONE: begin
          if (!run) begin
            state <= S_IDLE;
            rdy   <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          rdy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/unsigned_divider.sv
// Sequential restoring divider, one quotient bit per clock.
// Top level holds the R/Q/D datapath and the result registers.
module unsigned_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             rdy,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  logic [WIDTH:0]   r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;

  logic [WIDTH:0]   r_sh;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   r_nxt;
  logic [WIDTH-1:0] q_nxt;

  logic load;
  logic shift_en;
  logic accept;
  logic last;
  logic dz_in;

  assign dz_in = (divisor == '0);

  divider_control #(
    .WIDTH(WIDTH)
  ) u_ctrl (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .divisor_zero(dz_in),
    .trial_sign  (trial[WIDTH]),
    .load        (load),
    .shift_en    (shift_en),
    .accept      (accept),
    .last        (last),
    .busy        (busy),
    .rdy         (rdy)
  );

  // Shift {R,Q} left, trial-subtract D, restore on a negative result.
  always_comb begin
    r_sh  = {r[WIDTH-1:0], q[WIDTH-1]};
    trial = r_sh - {1'b0, d};
    r_nxt = accept ? trial : r_sh;
    q_nxt = {q[WIDTH-2:0], accept};
  end

  // Working registers and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r           <= '0;
      q           <= '0;
      d           <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (load) begin
      r           <= '0;
      q           <= dividend;
      d           <= divisor;
      div_by_zero <= dz_in;
      if (dz_in) begin
        quotient  <= '1;
        remainder <= dividend;
      end
    end else if (shift_en) begin
      r <= r_nxt;
      q <= q_nxt;
      if (last) begin
        quotient  <= q_nxt;
        remainder <= r_nxt[WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_unsigned_divider.sv
// Scoreboard bench for unsigned_divider (WIDTH=32).
// Stimulus pushes expected results; a monitor checks each rdy rise.
module tb_unsigned_divider;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         run = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         rdy;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int total = 0;
  int bad = 0;

  logic [2*W:0] sb[$];
  logic         rdy_prev = 1'b0;

  unsigned_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .rdy        (rdy),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [2*W:0] model(input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    if (b == 0) return {1'b1, {W{1'b1}}, a};
    return {1'b0, a / b, a % b};
  endfunction

  always @(negedge clk) begin
    if (rdy && !rdy_prev) begin
      if (sb.size() == 0) begin
        chk("unexpected_rdy", 1, 0);
      end else begin
        logic [2*W:0] e;
        e = sb.pop_front();
        chk("quotient", quotient, e[2*W-1:W]);
        chk("remainder", remainder, e[W-1:0]);
        chk("div_by_zero", div_by_zero, e[2*W]);
      end
    end
    rdy_prev = rdy;
  end

  task automatic do_op(input logic [W-1:0] a,
                       input logic [W-1:0] b,
                       input int hold);
    int n;
    int nb;
    logic [2*W:0] e;
    e = model(a, b);
    @(negedge clk);
    run = 1'b1;
    dividend = a;
    divisor = b;
    sb.push_back(e);
    n = 0;
    nb = 0;
    @(posedge clk);
    #1;
    n = 1;
    if (busy) nb++;
    run = (hold != 0);
    dividend = $urandom;
    divisor = $urandom;
    while (!rdy && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (busy) nb++;
      if (busy && rdy) chk("busy_and_rdy", 1, 0);
    end
    chk("latency", n, (b == 0) ? 1 : W + 1);
    chk("busy_cycles", nb, (b == 0) ? 0 : W);
    if (hold != 0) begin
      for (int i = 0; i < 5; i++) begin
        @(posedge clk);
        #1;
        chk("hold_rdy", rdy, 1);
        chk("hold_busy", busy, 0);
        chk("hold_q", quotient, e[2*W-1:W]);
        chk("hold_r", remainder, e[W-1:0]);
      end
      run = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("rdy_fall", rdy, 0);
    chk("idle_keep_q", quotient, e[2*W-1:W]);
  endtask

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_rdy", rdy, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_dz", div_by_zero, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    do_op(100, 7, 0);
    do_op(32'hFFFF_FFFF, 1, 0);
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op(3, 10, 0);
    do_op(5, 0, 0);
    do_op(9, 3, 0);
    do_op(0, 5, 0);

    @(negedge clk);
    run = 1'b1;
    dividend = 1000;
    divisor = 3;
    @(posedge clk);
    #1;
    run = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_rdy", rdy, 0);
    chk("abort_q", quotient, 0);
    chk("abort_r", remainder, 0);
    chk("abort_dz", div_by_zero, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_idle", busy, 0);
    do_op(1000, 3, 0);

    do_op(50, 7, 1);
    do_op(81, 9, 0);
    do_op(7, 0, 1);

    for (int k = 0; k < 25; k++) begin
      a = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 50)) : W'($urandom);
      case ($urandom_range(0, 4))
        0: b = W'($urandom_range(0, 3));
        1: b = W'($urandom_range(1, 1000));
        2: b = W'($urandom) >> $urandom_range(0, 31);
        default: b = W'($urandom);
      endcase
      do_op(a, b, int'($urandom_range(0, 5) == 0));
    end

    repeat (2) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
